// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt source arbiter.
package irq_pkg;

    localparam int IRQ_N_SRC_DEFAULT = 8;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQUEST = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational lowest-index-first priority encoder.
module irq_priority_encoder #(
    parameter int N_SRC = 8,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] vec,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    // Scan from the top down so the lowest set index is written last and wins.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_source_arbiter.sv
// Pends peripheral interrupt lines and forwards them one at a time to the core.
// Define IRQ_EDGE_DETECT_EN for rising-edge set events; default build is level-sensitive.
module irq_source_arbiter
    import irq_pkg::*;
#(
    parameter int N_SRC = IRQ_N_SRC_DEFAULT,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] src_i,
    input  logic [N_SRC-1:0] mask_i,
    input  logic             irq_taken_i,
    input  logic             irq_ret_i,
    output logic             irq_req_o,
    output logic [ID_W-1:0]  irq_id_o,
    output logic [N_SRC-1:0] pending_o
);

    irq_state_t       state, state_nxt;
    logic [ID_W-1:0]  id_nxt;
    logic [ID_W-1:0]  win_id;
    logic             win_vld;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] set_evt;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] eligible;
    logic             cur_ok;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N_SRC-1:0] src_q;
    logic             primed;

    // The first cycle after reset only samples history, so a line that is
    // already high coming out of reset is not mistaken for an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q  <= '0;
            primed <= 1'b0;
        end else begin
            src_q  <= src_i;
            primed <= 1'b1;
        end
    end

    assign set_evt = src_i & ~src_q & {N_SRC{primed}};
`else
    assign set_evt = src_i;
`endif

    assign eligible = pending & mask_i;
    assign cur_ok   = eligible[irq_id_o];

    irq_priority_encoder #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_enc (
        .vec   (eligible),
        .valid (win_vld),
        .id    (win_id)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IRQ_IDLE;
            irq_id_o <= '0;
        end else begin
            state    <= state_nxt;
            irq_id_o <= id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = irq_id_o;
        case (state)
            IRQ_IDLE: begin
                id_nxt = '0;
                if (win_vld) begin
                    state_nxt = IRQ_REQUEST;
                    id_nxt    = win_id;
                end
            end
            IRQ_REQUEST: begin
                if (irq_taken_i) begin
                    state_nxt = IRQ_SERVICE;
                end else if (!cur_ok) begin
                    // Mask dropped: withdraw the request but keep the line pending.
                    state_nxt = IRQ_IDLE;
                    id_nxt    = '0;
                end
            end
            IRQ_SERVICE: begin
                if (irq_ret_i) begin
                    state_nxt = IRQ_IDLE;
                    id_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IRQ_IDLE;
                id_nxt    = '0;
            end
        endcase
    end

    always_comb begin
        irq_req_o = (state == IRQ_REQUEST);
    end

    assign clr = (state == IRQ_SERVICE && irq_ret_i) ? (N_SRC'(1) << irq_id_o) : '0;

    // A set event in the clear cycle wins over the clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) pending <= '0;
        else       pending <= (pending & ~clr) | set_evt;
    end

    assign pending_o = pending;

endmodule
